// File: rtl/counter_ud_if.sv
// Control/status bundle for the up/down display counter.
// ss/ud steer the counter, q returns the registered count.
interface counter_ud_if;
  logic       ss;
  logic       ud;
  logic [7:0] q;

  modport master (
    output ss,
    output ud,
    input  q
  );

  modport slave (
    input  ss,
    input  ud,
    output q
  );
endinterface

// File: rtl/counter_ud.sv
// 8-bit up/down counter with prescaler and start/stop hold.
// Define COUNTERUD_BCD_EN for packed two-digit BCD counting.
module counter_ud #(
  parameter int DIV   = 1,
  parameter int DIV_W = 26
) (
  input  logic         clk,
  input  logic         rs,
  counter_ud_if.slave  bus
);

  localparam logic [DIV_W-1:0] LP_LAST = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [7:0]       r_q;
  logic             w_tick;
  logic [7:0]       w_q_next;

  assign w_tick = (r_div_cnt == LP_LAST);

`ifdef COUNTERUD_BCD_EN
  // Units roll first; tens move only on a units carry/borrow.
  always_comb begin
    w_q_next = r_q;
    if (bus.ud) begin
      if (r_q[3:0] == 4'd9) begin
        w_q_next[3:0] = 4'd0;
        w_q_next[7:4] = (r_q[7:4] == 4'd9) ? 4'd0
                      : r_q[7:4] + 4'd1;
      end else begin
        w_q_next[3:0] = r_q[3:0] + 4'd1;
      end
    end else begin
      if (r_q[3:0] == 4'd0) begin
        w_q_next[3:0] = 4'd9;
        w_q_next[7:4] = (r_q[7:4] == 4'd0) ? 4'd9
                      : r_q[7:4] - 4'd1;
      end else begin
        w_q_next[3:0] = r_q[3:0] - 4'd1;
      end
    end
  end
`else
  always_comb begin
    w_q_next = r_q;
    if (bus.ud) w_q_next = r_q + 8'd1;
    else        w_q_next = r_q - 8'd1;
  end
`endif

  always_ff @(posedge clk) begin
    if (rs) begin
      r_div_cnt <= '0;
      r_q       <= 8'h00;
    end else if (!bus.ss) begin
      if (w_tick) begin
        r_div_cnt <= '0;
        r_q       <= w_q_next;
      end else begin
        r_div_cnt <= r_div_cnt + 1'b1;
      end
    end
  end

  assign bus.q = r_q;

endmodule

// File: tb/tb_counter_ud.sv
// Directed bench for counter_ud, DIV=1 and DIV=4 instances.
// Expected values go through a scoreboard queue.
module tb_counter_ud;

  logic clk;
  logic rs1;
  logic rs4;

  counter_ud_if bus1 ();
  counter_ud_if bus4 ();

  counter_ud #(.DIV(1), .DIV_W(26)) u_dut1 (
    .clk (clk),
    .rs  (rs1),
    .bus (bus1.slave)
  );

  counter_ud #(.DIV(4), .DIV_W(26)) u_dut4 (
    .clk (clk),
    .rs  (rs4),
    .bus (bus4.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct {
    logic       which;
    logic [7:0] exp;
    string      tag;
  } sb_t;

  sb_t sb[$];
  int  errors = 0;
  int  checks = 0;

`ifdef COUNTERUD_BCD_EN
  localparam logic [7:0] MID = 8'h59;
`else
  localparam logic [7:0] MID = 8'h5A;
`endif

  function automatic logic [7:0] fnext(logic [7:0] v, logic up);
`ifdef COUNTERUD_BCD_EN
    int d;
    d = int'(v[7:4]) * 10 + int'(v[3:0]);
    d = up ? (d + 1) % 100 : (d + 99) % 100;
    return {4'(d / 10), 4'(d % 10)};
`else
    return up ? v + 8'd1 : v - 8'd1;
`endif
  endfunction

  task automatic step(input logic which, input logic [7:0] exp,
                      input string tag);
    sb_t        e;
    logic [7:0] obs;
    sb.push_back('{which, exp, tag});
    @(posedge clk);
    #1;
    e   = sb.pop_front();
    obs = e.which ? bus4.q : bus1.q;
    checks++;
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  // One DIV=4 period: three holding edges then the tick edge.
  task automatic period4(input logic [7:0] cur, input logic up,
                         output logic [7:0] nxt, input string tag);
    for (int k = 0; k < 3; k++) step(1'b1, cur, tag);
    nxt = fnext(cur, up);
    step(1'b1, nxt, tag);
  endtask

  logic [7:0] m1;
  logic [7:0] m4;
  int         guard;

  initial begin
    rs1      = 1'b1;
    rs4      = 1'b1;
    bus1.ss  = 1'b0;
    bus1.ud  = 1'b1;
    bus4.ss  = 1'b0;
    bus4.ud  = 1'b1;
    m1       = 8'h00;

    step(1'b0, 8'h00, "reset1");
    rs1 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m1 = fnext(m1, 1'b1);
      step(1'b0, m1, "count_up");
    end

    guard = 0;
    do begin
      m1 = fnext(m1, 1'b1);
      step(1'b0, m1, "wrap_up");
      guard++;
    end while (m1 != 8'h00 && guard < 300);
    checks++;
    assert (guard < 300) else begin
      errors++;
      $error("FAIL wrap_bound observed=%0d expected=<300", guard);
    end

    bus1.ud = 1'b0;
    m1 = fnext(m1, 1'b0);
    step(1'b0, m1, "wrap_down0");
    m1 = fnext(m1, 1'b0);
    step(1'b0, m1, "wrap_down1");

    bus1.ud = 1'b1;
    guard = 0;
    while (m1 != MID && guard < 300) begin
      m1 = fnext(m1, 1'b1);
      step(1'b0, m1, "to_mid");
      guard++;
    end
    rs1 = 1'b1;
    m1  = 8'h00;
    step(1'b0, m1, "mid_reset");
    rs1 = 1'b0;
    m1  = fnext(m1, 1'b1);
    step(1'b0, m1, "after_reset");

    step(1'b1, 8'h00, "reset4");
    rs4 = 1'b0;
    period4(8'h00, 1'b1, m4, "div4_first");
    period4(m4, 1'b1, m4, "div4_second");
    step(1'b1, m4, "pre_stop");
    step(1'b1, m4, "pre_stop");
    bus4.ss = 1'b1;
    for (int k = 0; k < 10; k++) step(1'b1, m4, "stop_hold");
    bus4.ss = 1'b0;
    step(1'b1, m4, "resume_wait");
    m4 = fnext(m4, 1'b1);
    step(1'b1, m4, "resume_tick");

    rs4 = 1'b1;
    step(1'b1, 8'h00, "reset4b");
    rs4 = 1'b0;
    m4 = 8'h00;
    guard = 0;
    while (m4 != 8'h10 && guard < 40) begin
      period4(m4, 1'b1, m4, "to_10");
      guard++;
    end
    step(1'b1, m4, "dir_hold");
    step(1'b1, m4, "dir_hold");
    bus4.ud = 1'b0;
    step(1'b1, m4, "dir_hold");
    m4 = fnext(m4, 1'b0);
    step(1'b1, m4, "dir_tick");
    period4(m4, 1'b0, m4, "dir_period");

`ifdef COUNTERUD_BCD_EN
    checks++;
    assert (bus4.q[3:0] <= 4'd9) else begin
      errors++;
      $error("FAIL bcd_units observed=%h expected<=9", bus4.q[3:0]);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
